// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_arbiter : two-requester front end sharing one SIZE-bit ALU             |
// |               (add/sub/and/or with O/Z/N flags) over valid/ready channels  |
// | Option      : define ALU_ARB_RR_EN for round-robin, else fixed priority    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic [1:0]      req0_ctrl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  input  logic [1:0]      req1_ctrl,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_r,
  output logic            rsp_o,
  output logic            rsp_z,
  output logic            rsp_n,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] C_OP_ADD = 2'b00;
  localparam logic [1:0] C_OP_SUB = 2'b01;
  localparam logic [1:0] C_OP_AND = 2'b10;
  localparam logic [1:0] C_OP_OR  = 2'b11;

  logic [1:0]      r_state;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [1:0]      r_ctrl;
  logic            r_id;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_accept;
  logic [SIZE:0]   w_res;
  logic            w_z;
  logic            w_n;

`ifdef ALU_ARB_RR_EN
  logic r_last;

  // On contention the port that did not win last time goes first.
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant0 = r_last;
      w_grant1 = ~r_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end
`else
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  assign w_accept   = rst_n & (r_state == S_IDLE) & (w_grant0 | w_grant1);
  assign req0_ready = rst_n & (r_state == S_IDLE) & w_grant0;
  assign req1_ready = rst_n & (r_state == S_IDLE) & w_grant1;
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);

  // Bit SIZE carries the carry/borrow for arithmetic and stays 0 for logic ops.
  always_comb begin
    w_res = '0;
    case (r_ctrl)
      C_OP_ADD: w_res = {1'b0, r_a} + {1'b0, r_b};
      C_OP_SUB: w_res = {1'b0, r_a} - {1'b0, r_b};
      C_OP_AND: w_res = {1'b0, r_a & r_b};
      C_OP_OR:  w_res = {1'b0, r_a | r_b};
      default:  w_res = '0;
    endcase
  end

  assign w_z = ~|w_res[SIZE-1:0];
  assign w_n = ~r_ctrl[1] & w_res[SIZE-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= C_OP_ADD;
      r_id    <= 1'b0;
      rsp_id  <= 1'b0;
      rsp_r   <= '0;
      rsp_o   <= 1'b0;
      rsp_z   <= 1'b0;
      rsp_n   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant1 ? req1_a    : req0_a;
            r_b     <= w_grant1 ? req1_b    : req0_b;
            r_ctrl  <= w_grant1 ? req1_ctrl : req0_ctrl;
            r_id    <= w_grant1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_r   <= w_res[SIZE-1:0];
          rsp_o   <= w_res[SIZE];
          rsp_z   <= w_z;
          rsp_n   <= w_n;
          rsp_id  <= r_id;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_arbiter : directed + random self-checking bench for alu_arbiter     |
// | Revision       : 1.0 - initial release                                     |
// +----------------------------------------------------------------------------+
module tb_alu_arbiter;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]      req0_ctrl, req1_ctrl;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [SIZE-1:0] rsp_r;
  logic            rsp_o, rsp_z, rsp_n, busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_o(rsp_o), .rsp_z(rsp_z), .rsp_n(rsp_n),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: {o, z, n, r} from plain unsigned arithmetic on 64-bit integers.
  function automatic logic [34:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned la, lb, s;
    logic [31:0] r;
    logic o, n;
    la = 64'(a);
    lb = 64'(b);
    case (op)
      2'b00: begin s = la + lb; o = (s > 64'hFFFF_FFFF); r = s[31:0]; n = r[31]; end
      2'b01: begin o = (la < lb); r = a - b; n = r[31]; end
      2'b10: begin o = 1'b0; r = a & b; n = 1'b0; end
      default: begin o = 1'b0; r = a | b; n = 1'b0; end
    endcase
    return {o, (r == 32'd0), n, r};
  endfunction

  function automatic logic [34:0] observed();
    return {rsp_o, rsp_z, rsp_n, rsp_r};
  endfunction

  // Entered at posedge+1 with the block idle and rsp_ready high.
  task automatic run_op(input bit port, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [34:0] expv;
    int n;
    expv = model(op, a, b);
    if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = op; end
    else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = op; end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, " ready"}, 64'(port ? req1_ready : req0_ready), 64'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, " exec"}, 64'({rsp_valid, busy}), 64'(2'b01));
    @(posedge clk); #1;
    chk({tag, " resp"}, 64'({rsp_valid, rsp_id}), 64'({1'b1, port}));
    chk({tag, " result"}, 64'(observed()), 64'(expv));
    @(posedge clk); #1;
  endtask

  initial begin
    int grants[$];
    int gcyc[$];
    int pend[$];
    logic [34:0] hold;
    logic [34:0] res0, res1;
    int exp_g;

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h1; req0_b = 32'h2; req0_ctrl = 2'b00;
    req1_a = 32'h3; req1_b = 32'h4; req1_ctrl = 2'b01;

    // Reset with both valids high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset readys", 64'({req0_ready, req1_ready}), 64'(0));
    end
    chk("reset outputs", 64'({rsp_valid, busy, rsp_id, rsp_o, rsp_z, rsp_n, rsp_r}), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    run_op(1'b0, 2'b00, 32'hFFFFF000, 32'hFFFFFFFF, "add carry");
    chk("add carry value", 64'(observed()), 64'({1'b1, 1'b0, 1'b1, 32'hFFFFEFFF}));
    run_op(1'b0, 2'b00, 32'hFFFFFFFF, 32'h00000001, "add zero");
    chk("add zero value", 64'(observed()), 64'({1'b1, 1'b1, 1'b0, 32'h0}));
    run_op(1'b0, 2'b01, 32'h67676767, 32'h12431243, "sub");
    chk("sub value", 64'(observed()), 64'({1'b0, 1'b0, 1'b0, 32'h55245524}));
    run_op(1'b0, 2'b01, 32'hFFFFFFFC, 32'hFFFFFFFC, "sub zero");
    chk("sub zero value", 64'(observed()), 64'({1'b0, 1'b1, 1'b0, 32'h0}));
    run_op(1'b1, 2'b10, 32'hF0F0F0F0, 32'hCFCFCFCF, "and p1");
    chk("and value", 64'(observed()), 64'({1'b0, 1'b0, 1'b0, 32'hC0C0C0C0}));
    run_op(1'b1, 2'b11, 32'h00000000, 32'h11000001, "or p1");
    chk("or value", 64'({rsp_id, observed()}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h11000001}));

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, rb, "random");
    end

    // Contention from a fresh reset, both valids held, consumer always ready
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_ctrl = 2'b00;
    req1_valid = 1'b1; req1_a = 32'h00F0; req1_b = 32'h0F00; req1_ctrl = 2'b11;
    res0 = model(2'b00, 32'h1, 32'h2);
    res1 = model(2'b11, 32'h00F0, 32'h0F00);
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("one-hot ready", 64'(req0_ready & req1_ready), 64'(0));
      if (rsp_valid) begin
        if (pend.size() > 0) begin
          exp_g = pend.pop_front();
          chk("contention rsp", 64'({rsp_id, observed()}),
              64'({exp_g[0], (exp_g == 1) ? res1 : res0}));
        end else begin
          chk("unexpected rsp", 64'(1), 64'(0));
        end
      end
      if (req0_ready) begin grants.push_back(0); gcyc.push_back(c); pend.push_back(0); end
      if (req1_ready) begin grants.push_back(1); gcyc.push_back(c); pend.push_back(1); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < grants.size() && i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      chk("grant port", 64'(grants[i]), 64'(exp_g));
      chk("grant spacing", 64'(gcyc[i]), 64'(3 * i));
    end
    @(posedge clk); #1;

    // Backpressure: result held for 5 cycles, nobody granted meanwhile
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h9; req0_ctrl = 2'b01;
    hold = model(2'b01, 32'h5, 32'h9);
    #1;
    chk("bp ready", 64'(req0_ready), 64'(1));
    @(posedge clk); #1;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp hold flags", 64'({rsp_valid, busy, req0_ready, req1_ready}), 64'(4'b1100));
      chk("bp hold value", 64'({rsp_id, observed()}), 64'({1'b0, hold}));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp release", 64'({rsp_valid, busy}), 64'(0));
    chk("bp retained", 64'(observed()), 64'(hold));

    // Reset while in EXEC discards the operation
    req1_valid = 1'b1; req1_a = 32'hFFFF; req1_b = 32'hFF00; req1_ctrl = 2'b10;
    #1;
    chk("mid rst ready", 64'(req1_ready), 64'(1));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("mid rst exec", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid rst state", 64'({rsp_valid, busy, rsp_id, rsp_o, rsp_z, rsp_n, rsp_r}), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid rst no rsp", 64'({rsp_valid, busy}), 64'(0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
